// File: rtl/fp8_pack_stream.sv
// Streaming float32 -> FP8 (E4M3 / E5M2) converter that packs LANES bytes per output word
// and counts saturation events.
module fp8_pack_stream #(
   parameter int unsigned LANES    = 4,
   parameter int unsigned SATCNT_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fmt_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [31:0]           in_data_i,
   input  logic                  in_last_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [8*LANES-1:0]    out_data_o,
   output logic [LANES-1:0]      out_keep_o,
   output logic                  out_last_o,
   output logic [SATCNT_W-1:0]   sat_cnt_o,
   input  logic                  sat_clr_i,
   output logic                  busy_o
);

   localparam int unsigned IDX_W = $clog2(LANES);

   // Returns {sat, sign, exp, man}; e5 selects E5M2, otherwise E4M3.
   function automatic logic [8:0] cvt_fp8(input logic [31:0] f, input logic e5);
      logic               sgn;
      logic [7:0]         ef;
      logic [22:0]        mf;
      logic [4:0]         mb;
      logic [4:0]         eall;
      logic signed [9:0]  te;
      logic [2:0]         keep_m;
      logic [22:0]        rem_mask;
      logic [9:0]         sum;
      logic [26:0]        sx;
      logic [26:0]        sub_mask;
      logic signed [10:0] sh_calc;
      logic [4:0]         sh;
      logic [4:0]         r;
      logic [4:0]         maxsub;
      logic               guard;
      logic               sticky;
      logic               up;
      logic               sat;
      logic [6:0]         mag;

      sgn      = f[31];
      ef       = f[30:23];
      mf       = f[22:0];
      mb       = e5 ? 5'd2 : 5'd3;
      eall     = e5 ? 5'd31 : 5'd15;
      te       = $signed({2'b00, ef}) - 10'sd127 + (e5 ? 10'sd15 : 10'sd7);
      keep_m   = '0;
      rem_mask = '0;
      sum      = '0;
      sx       = '0;
      sub_mask = '0;
      sh_calc  = '0;
      sh       = '0;
      r        = '0;
      maxsub   = '0;
      guard    = 1'b0;
      sticky   = 1'b0;
      up       = 1'b0;
      sat      = 1'b0;
      mag      = '0;

      if (ef == 8'hFF) begin
         mag = (e5 ? 7'h7C : 7'h78) | {6'b0, (mf != '0)};
      end else if (ef == 8'h00) begin
         mag = '0;
      end else if (te >= $signed({5'b0, eall})) begin
         sat = 1'b1;
         mag = e5 ? 7'h7B : 7'h77;
      end else if (te >= 10'sd1) begin
         keep_m   = 3'(mf >> (5'd23 - mb));
         guard    = mf[5'd22 - mb];
         rem_mask = (23'd1 << (5'd22 - mb)) - 23'd1;
         sticky   = |(mf & rem_mask);
         up       = guard & (sticky | keep_m[0]);
         sum      = ({5'b0, te[4:0]} << mb) + {7'b0, keep_m} + {9'b0, up};
         if ((sum >> mb) >= {5'b0, eall}) begin
            sat = 1'b1;
            mag = e5 ? 7'h7B : 7'h77;
         end else begin
            mag = sum[6:0];
         end
      end else begin
         // Align so that bit 0 of the shifted significand is one subnormal step.
         sh_calc  = 11'sd24 - $signed({6'b0, mb}) - $signed({te[9], te});
         sh       = (sh_calc > 11'sd26) ? 5'd26 : sh_calc[4:0];
         sx       = {3'b000, 1'b1, mf};
         r        = 5'(sx >> sh);
         guard    = sx[sh - 5'd1];
         sub_mask = (27'd1 << (sh - 5'd1)) - 27'd1;
         sticky   = |(sx & sub_mask);
         up       = guard & (sticky | r[0]);
         r        = r + {4'b0, up};
         maxsub   = (5'd1 << mb) - 5'd1;
         mag      = (r > maxsub) ? {2'b0, maxsub} : {2'b0, r};
      end
      return {sat, sgn, mag};
   endfunction

   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                fmt_q, fmt_d;
   logic [8*LANES-1:0]  acc_q, acc_d;
   logic [LANES-1:0]    acc_keep_q, acc_keep_d;
   logic [8*LANES-1:0]  out_data_q, out_data_d;
   logic [LANES-1:0]    out_keep_q, out_keep_d;
   logic                out_last_q, out_last_d;
   logic                out_valid_q, out_valid_d;
   logic [SATCNT_W-1:0] sat_cnt_q, sat_cnt_d;
   logic                busy_q, busy_d;

   logic [8:0] cvt_e4m3, cvt_e5m2, cvt_sel;
   logic       fmt_use, accept, close;

   always_comb begin
      cvt_e4m3    = cvt_fp8(in_data_i, 1'b0);
      cvt_e5m2    = cvt_fp8(in_data_i, 1'b1);
      fmt_use     = (idx_q == '0) ? fmt_i : fmt_q;
      cvt_sel     = fmt_use ? cvt_e5m2 : cvt_e4m3;
      in_ready_o  = ~rst_i & (~out_valid_q | out_ready_i);
      accept      = in_valid_i & in_ready_o;
      close       = accept & (in_last_i | (idx_q == IDX_W'(LANES - 1)));

      idx_d       = idx_q;
      fmt_d       = fmt_q;
      acc_d       = acc_q;
      acc_keep_d  = acc_keep_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      sat_cnt_d   = sat_cnt_q;

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (idx_q == '0) begin
            fmt_d = fmt_i;
         end
         acc_d[{idx_q, 3'b000} +: 8] = cvt_sel[7:0];
         acc_keep_d[idx_q]           = 1'b1;
         if (close) begin
            out_data_d  = acc_d;
            out_keep_d  = acc_keep_d;
            out_last_d  = in_last_i;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_keep_d  = '0;
            idx_d       = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      // Clear wins, but a saturating accept in the same cycle still counts once.
      if (sat_clr_i) begin
         sat_cnt_d = (accept && cvt_sel[8]) ? SATCNT_W'(1) : '0;
      end else if (accept && cvt_sel[8] && !(&sat_cnt_q)) begin
         sat_cnt_d = sat_cnt_q + SATCNT_W'(1);
      end

      busy_d = out_valid_d | (idx_d != '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q       <= '0;
         fmt_q       <= 1'b0;
         acc_q       <= '0;
         acc_keep_q  <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sat_cnt_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         fmt_q       <= fmt_d;
         acc_q       <= acc_d;
         acc_keep_q  <= acc_keep_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         sat_cnt_q   <= sat_cnt_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_keep_o  = out_keep_q;
   assign out_last_o  = out_last_q;
   assign sat_cnt_o   = sat_cnt_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_fp8_pack_stream.sv
// Bench for fp8_pack_stream: directed scenarios plus a randomized stream scored against a
// value-level FP8 rounding model.
module tb_fp8_pack_stream;

   localparam int unsigned LANES    = 4;
   localparam int unsigned SATCNT_W = 2;
   localparam logic [31:0] F_ONE  = 32'h3F800000;
   localparam logic [31:0] F_TWO  = 32'h40000000;
   localparam logic [31:0] F_BIG  = 32'h447A0000;
   localparam logic [31:0] F_ZERO = 32'h00000000;

   logic                clk = 1'b0;
   logic                rst, fmt, in_valid, in_ready, in_last;
   logic [31:0]         in_data;
   logic                out_valid, out_ready, out_last, sat_clr, busy;
   logic [8*LANES-1:0]  out_data;
   logic [LANES-1:0]    out_keep;
   logic [SATCNT_W-1:0] sat_cnt;

   int nvec = 0;
   int nerr = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   fp8_pack_stream #(.LANES(LANES), .SATCNT_W(SATCNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .fmt_i(fmt), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_keep_o(out_keep), .out_last_o(out_last), .sat_cnt_o(sat_cnt),
      .sat_clr_i(sat_clr), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic real p2(input int k);
      real r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real code_val(input int c, input logic e5);
      int mb = e5 ? 2 : 3;
      int bias = e5 ? 15 : 7;
      int e = c >> mb;
      int m = c & ((1 << mb) - 1);
      if (e == 0) return real'(m) * p2(1 - bias - mb);
      return real'(m + (1 << mb)) * p2(e - bias - mb);
   endfunction

   // Nearest FP8 code by value (ties to even code), saturating and subnormal-clamped.
   function automatic logic [8:0] fp8_ref(input logic [31:0] x, input logic e5);
      int  mb, bias, maxc, minn, ex, mx, best, lim;
      real a, d, bd, v, top_ulp;
      mb   = e5 ? 2 : 3;
      bias = e5 ? 15 : 7;
      maxc = e5 ? 'h7B : 'h77;
      minn = 1 << mb;
      ex   = int'(x[30:23]);
      mx   = int'(x[22:0]);
      if (ex == 255)
         return {1'b0, x[31], (mx != 0) ? (e5 ? 7'h7D : 7'h79) : (e5 ? 7'h7C : 7'h78)};
      if (ex == 0) a = real'(mx) * p2(-149);
      else a = real'(mx + 8388608) * p2(ex - 150);
      top_ulp = p2((maxc >> mb) - bias - mb);
      if (a >= code_val(maxc, e5) + top_ulp / 2.0) return {1'b1, x[31], maxc[6:0]};
      lim  = (a < code_val(minn, e5)) ? minn - 1 : maxc;
      best = 0;
      bd   = a;
      for (int c = 1; c <= lim; c++) begin
         v = code_val(c, e5);
         d = (a > v) ? a - v : v - a;
         if (d < bd || (d == bd && (c % 2) == 0)) begin
            best = c;
            bd   = d;
         end
      end
      return {1'b0, x[31], best[6:0]};
   endfunction

   function automatic logic [31:0] rand_f32();
      logic [31:0] x = $urandom;
      int unsigned k = $urandom_range(0, 15);
      if (k == 0) x[30:0] = '0;
      else if (k == 1) x[30:0] = {8'hFF, 23'h0};
      else if (k == 2) begin x[30:23] = 8'hFF; x[0] = 1'b1; end
      else if (k == 3) x[30:23] = 8'h00;
      else if (k == 4) begin x[30:23] = 8'($urandom_range(100, 146)); x[19:0] = 20'h80000; end
      else if (k == 5) begin x[30:23] = 8'($urandom_range(100, 146)); x[20:0] = 21'h100000; end
      else x[30:23] = 8'($urandom_range(100, 146));
      return x;
   endfunction

   task automatic test_reset();
      rst = 1'b1; fmt = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b1; sat_clr = 1'b0;
      #1;
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b want 0", in_ready); end
      step(); step();
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      nvec++; if (out_data !== '0) begin nerr++; $display("FAIL reset_data: got %h want 0", out_data); end
      nvec++; if (out_keep !== '0) begin nerr++; $display("FAIL reset_keep: got %h want 0", out_keep); end
      nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL reset_last: got %b want 0", out_last); end
      nvec++; if (sat_cnt !== '0) begin nerr++; $display("FAIL reset_sat: got %0d want 0", sat_cnt); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      #1;
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_e4m3_word();
      logic [31:0] v [4] = '{F_ONE, 32'hC0000000, 32'h3F000000, F_BIG};
      fmt = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = v[i];
         step();
         if (i < 3) begin
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL e4m3_early_valid lane %0d: got %b want 0", i, out_valid); end
         end
      end
      in_valid = 1'b0;
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL e4m3_valid: got %b want 1", out_valid); end
      nvec++; if (out_data !== 32'h7730C038) begin nerr++; $display("FAIL e4m3_data: got %h want 7730c038", out_data); end
      nvec++; if (out_keep !== 4'hF) begin nerr++; $display("FAIL e4m3_keep: got %h want f", out_keep); end
      nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL e4m3_last: got %b want 0", out_last); end
      nvec++; if (sat_cnt !== 2'd1) begin nerr++; $display("FAIL e4m3_sat: got %0d want 1", sat_cnt); end
      step();
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL e4m3_drain: got %b want 0", out_valid); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL e4m3_busy: got %b want 0", busy); end
   endtask

   task automatic test_e5m2_flush();
      fmt = 1'b1; in_valid = 1'b1; in_data = F_ONE; in_last = 1'b0;
      step();
      in_data = 32'h7FC00000; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL e5m2_valid: got %b want 1", out_valid); end
      nvec++; if (out_data !== 32'h00007D3C) begin nerr++; $display("FAIL e5m2_data: got %h want 00007d3c", out_data); end
      nvec++; if (out_keep !== 4'h3) begin nerr++; $display("FAIL e5m2_keep: got %h want 3", out_keep); end
      nvec++; if (out_last !== 1'b1) begin nerr++; $display("FAIL e5m2_last: got %b want 1", out_last); end
      step();
   endtask

   task automatic test_backpressure();
      fmt = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = F_ONE;
      repeat (4) step();
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid: got %b want 1", out_valid); end
      for (int i = 0; i < 5; i++) begin
         nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready cyc %0d: got %b want 0", i, in_ready); end
         nvec++; if (out_data !== 32'h38383838 || out_keep !== 4'hF || out_valid !== 1'b1)
            begin nerr++; $display("FAIL bp_hold cyc %0d: got %h/%h/%b want 38383838/f/1", i, out_data, out_keep, out_valid); end
         step();
      end
      out_ready = 1'b1;
      #1;
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      for (int i = 0; i < 8; i++) begin
         in_data = (i < 4) ? F_ONE : F_TWO;
         step();
         if (i == 3) begin
            nvec++; if (out_valid !== 1'b1 || out_data !== 32'h38383838)
               begin nerr++; $display("FAIL bp_word0: got %b/%h want 1/38383838", out_valid, out_data); end
         end else if (i == 7) begin
            nvec++; if (out_valid !== 1'b1 || out_data !== 32'h40404040)
               begin nerr++; $display("FAIL bp_word1: got %b/%h want 1/40404040", out_valid, out_data); end
         end else begin
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_stream_valid %0d: got %b want 0", i, out_valid); end
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_fmt_latch();
      fmt = 1'b0; in_valid = 1'b1; in_data = F_ONE; out_ready = 1'b1;
      step();
      fmt = 1'b1;
      repeat (3) step();
      nvec++; if (out_valid !== 1'b1 || out_data !== 32'h38383838)
         begin nerr++; $display("FAIL fmt_latch_word0: got %b/%h want 1/38383838", out_valid, out_data); end
      repeat (4) step();
      nvec++; if (out_valid !== 1'b1 || out_data !== 32'h3C3C3C3C)
         begin nerr++; $display("FAIL fmt_latch_word1: got %b/%h want 1/3c3c3c3c", out_valid, out_data); end
      in_valid = 1'b0; fmt = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_word();
      fmt = 1'b0; in_valid = 1'b1; in_data = F_ONE; out_ready = 1'b1;
      repeat (2) step();
      in_valid = 1'b0;
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
      rst = 1'b1;
      #1;
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
      step();
      nvec++; if (busy !== 1'b0 || out_valid !== 1'b0)
         begin nerr++; $display("FAIL midrst_state: got busy %b valid %b want 0 0", busy, out_valid); end
      rst = 1'b0; in_valid = 1'b1; in_data = F_TWO;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i < 3) begin
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_early %0d: got %b want 0", i, out_valid); end
         end
      end
      nvec++; if (out_valid !== 1'b1 || out_data !== 32'h40404040 || out_keep !== 4'hF)
         begin nerr++; $display("FAIL midrst_word: got %b/%h/%h want 1/40404040/f", out_valid, out_data, out_keep); end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_sat_counter();
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      nvec++; if (sat_cnt !== 2'd0) begin nerr++; $display("FAIL sat_clear0: got %0d want 0", sat_cnt); end
      fmt = 1'b0; in_valid = 1'b1; in_data = F_BIG; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         nvec++; if (sat_cnt !== 2'((i < 3) ? i + 1 : 3))
            begin nerr++; $display("FAIL sat_count %0d: got %0d want %0d", i, sat_cnt, (i < 3) ? i + 1 : 3); end
      end
      sat_clr = 1'b1;
      step();
      nvec++; if (sat_cnt !== 2'd1) begin nerr++; $display("FAIL sat_clr_with_sat: got %0d want 1", sat_cnt); end
      in_valid = 1'b0;
      step();
      sat_clr = 1'b0;
      nvec++; if (sat_cnt !== 2'd0) begin nerr++; $display("FAIL sat_clr_alone: got %0d want 0", sat_cnt); end
      in_valid = 1'b1; in_data = F_ZERO; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      nvec++; if (out_valid !== 1'b1 || out_data !== 32'h00007777 || out_keep !== 4'h7 || out_last !== 1'b1)
         begin nerr++; $display("FAIL sat_flush_word: got %b/%h/%h/%b want 1/00007777/7/1", out_valid, out_data, out_keep, out_last); end
      step();
   endtask

   task automatic test_random_stream();
      word_t       q[$];
      word_t       w;
      logic [7:0]  m_bytes [4];
      logic [3:0]  m_keep;
      int          m_idx, m_sat;
      logic        m_fmt, exp_v, exp_r, acc, s, f;
      logic [8:0]  r;
      rst = 1'b1; in_valid = 1'b0; sat_clr = 1'b0;
      step();
      rst = 1'b0;
      m_idx = 0; m_sat = 0; m_fmt = 1'b0; m_keep = '0;
      for (int k = 0; k < 4; k++) m_bytes[k] = '0;
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = rand_f32();
         in_last   = ($urandom_range(0, 7) == 0);
         fmt       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         sat_clr   = ($urandom_range(0, 31) == 0);
         #2;
         exp_v = (q.size() != 0);
         exp_r = !exp_v || out_ready;
         nvec++; if (out_valid !== exp_v) begin nerr++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, exp_v); end
         nvec++; if (in_ready !== exp_r) begin nerr++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, exp_r); end
         nvec++; if (sat_cnt !== 2'(m_sat)) begin nerr++; $display("FAIL rnd_sat c%0d: got %0d want %0d", c, sat_cnt, m_sat); end
         nvec++; if (busy !== (exp_v || m_idx != 0)) begin nerr++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, exp_v || m_idx != 0); end
         if (exp_v) begin
            nvec++; if (out_data !== q[0].data || out_keep !== q[0].keep || out_last !== q[0].last)
               begin nerr++; $display("FAIL rnd_word c%0d: got %h/%h/%b want %h/%h/%b", c, out_data, out_keep, out_last, q[0].data, q[0].keep, q[0].last); end
            if (out_ready) void'(q.pop_front());
         end
         acc = in_valid && exp_r;
         s   = 1'b0;
         if (acc) begin
            f = (m_idx == 0) ? fmt : m_fmt;
            if (m_idx == 0) m_fmt = fmt;
            r = fp8_ref(in_data, f);
            s = r[8];
            m_bytes[m_idx] = r[7:0];
            m_keep[m_idx]  = 1'b1;
            if (in_last || m_idx == LANES - 1) begin
               w.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
               w.keep = m_keep;
               w.last = in_last;
               q.push_back(w);
               for (int k = 0; k < 4; k++) m_bytes[k] = '0;
               m_keep = '0;
               m_idx  = 0;
            end else begin
               m_idx++;
            end
         end
         if (sat_clr) m_sat = (acc && s) ? 1 : 0;
         else if (acc && s && m_sat < 3) m_sat++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0; in_last = 1'b0;
      step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_e4m3_word();
      test_e5m2_flush();
      test_backpressure();
      test_fmt_latch();
      test_reset_mid_word();
      test_sat_counter();
      test_random_stream();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
